// File: rtl/node_memory.sv
// Decision-tree node store: assembles node words from a bit-serial configuration
// stream and serves registered reads to the downstream control stage.
module node_memory #(
    parameter int FEATURES      = 3,
    parameter int COEFF_WIDTH   = 4,
    parameter int BIAS_WIDTH    = 10,
    parameter int MAX_CLUSTERS  = 5,
    parameter int CHANNEL_COUNT = 1,
    localparam int NODE_SIZE    = 2 + FEATURES + (FEATURES - 1) * COEFF_WIDTH + BIAS_WIDTH + 1,
    localparam int CH_W         = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int NODE_W       = $clog2(MAX_CLUSTERS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_clear,
    input  logic                 cfg_valid,
    input  logic                 cfg_bit,
    input  logic [CH_W-1:0]      ch_index,
    input  logic [NODE_W-1:0]    node_index,
    input  logic                 read_mem,
    output logic [NODE_SIZE-1:0] node_data,
    output logic                 mem_ready,
    output logic                 load_done,
    output logic                 cfg_overflow
);

    localparam int NODE_SLOTS = MAX_CLUSTERS;
    localparam int DEPTH      = CHANNEL_COUNT * NODE_SLOTS;
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BCNT_W     = $clog2(NODE_SIZE);

    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(NODE_SIZE - 1);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NODE_SLOTS - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CHANNEL_COUNT - 1);

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [CH_W-1:0]   ch,
                                                   input logic [NODE_W-1:0] node);
        return ADDR_W'(32'(ch) * 32'(NODE_SLOTS) + 32'(node));
    endfunction

    logic [NODE_SIZE-1:0] mem [DEPTH];

    logic [NODE_SIZE-2:0] sr;
    logic [BCNT_W-1:0]    bcnt;
    logic [NODE_W-1:0]    wnode;
    logic [CH_W-1:0]      wch;
    logic                 full;

    logic                 accept;
    logic                 word_end;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_in_range;

    // cfg_clear wins over a coincident cfg_valid, so that bit is simply not accepted
    assign accept      = cfg_valid & ~full & ~cfg_clear;
    assign word_end    = accept && (bcnt == LAST_BIT);
    assign wr_addr     = lin_addr(wch, wnode);
    assign rd_addr     = lin_addr(ch_index, node_index);
    assign rd_in_range = (32'(node_index) < 32'(NODE_SLOTS)) &&
                         (32'(ch_index) < 32'(CHANNEL_COUNT));
    assign mem_ready   = full;

    always_ff @(posedge clk) begin
        if (accept) begin
            sr <= {sr[NODE_SIZE-3:0], cfg_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (word_end) begin
            mem[wr_addr] <= {sr, cfg_bit};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt         <= '0;
            wnode        <= '0;
            wch          <= '0;
            full         <= 1'b0;
            load_done    <= 1'b0;
            cfg_overflow <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (cfg_clear) begin
                bcnt         <= '0;
                wnode        <= '0;
                wch          <= '0;
                full         <= 1'b0;
                cfg_overflow <= 1'b0;
            end else if (cfg_valid && full) begin
                cfg_overflow <= 1'b1;
            end else if (word_end) begin
                bcnt <= '0;
                if (wnode == LAST_NODE) begin
                    wnode <= '0;
                    if (wch == LAST_CH) begin
                        wch       <= '0;
                        full      <= 1'b1;
                        load_done <= 1'b1;
                    end else begin
                        wch <= wch + 1'b1;
                    end
                end else begin
                    wnode <= wnode + 1'b1;
                end
            end else if (accept) begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Read stage: one-cycle latency; unmapped addresses read as an all-zero leaf word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            node_data <= '0;
        end else if (read_mem) begin
            node_data <= rd_in_range ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_node_memory.sv
// Directed bench for node_memory: reads are scoreboarded, status flags checked inline.
module tb_node_memory;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_clear = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_bit = 1'b0;
    logic [0:0]  ch_index = '0;
    logic [2:0]  node_index = '0;
    logic        read_mem = 1'b0;
    logic [23:0] node_data;
    logic        mem_ready;
    logic        load_done;
    logic        cfg_overflow;

    int nvec = 0;
    int nmis = 0;

    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;
    logic        sample_req = 1'b0;
    logic        samp_q = 1'b0;

    logic [23:0] w1 [5] = '{24'h000001, 24'h000002, 24'h000003, 24'h000004, 24'h000005};
    logic [23:0] wa [5] = '{24'hABCDEF, 24'hABCDEF, 24'hABCDEF, 24'hABCDEF, 24'hABCDEF};
    logic [23:0] w5 [5] = '{24'h123456, 24'h654321, 24'hA5A5A5, 24'h5A5A5A, 24'hFFFFFF};
    logic [23:0] w6 [5] = '{24'h800001, 24'h0F0F0F, 24'hF0F0F0, 24'h00FF00, 24'hC3C3C3};

    always #5 clk = ~clk;

    node_memory dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_clear    (cfg_clear),
        .cfg_valid    (cfg_valid),
        .cfg_bit      (cfg_bit),
        .ch_index     (ch_index),
        .node_index   (node_index),
        .read_mem     (read_mem),
        .node_data    (node_data),
        .mem_ready    (mem_ready),
        .load_done    (load_done),
        .cfg_overflow (cfg_overflow)
    );

    // Monitor: compares node_data on the falling edge after each requested sample
    always @(posedge clk) samp_q <= sample_req;

    always @(negedge clk) begin
        if (samp_q) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nmis++;
                $display("FAIL node_data: got %h with no expected word queued", node_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (node_data !== mon_exp) begin
                    nmis++;
                    $display("FAIL node_data: got %h expected %h", node_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input int node, input int ch, input logic [23:0] exp);
        node_index = 3'(node);
        ch_index   = 1'(ch);
        read_mem   = 1'b1;
        sample_req = 1'b1;
        exp_q.push_back(exp);
        tick();
        read_mem   = 1'b0;
        sample_req = 1'b0;
    endtask

    task automatic hold(input int node, input logic [23:0] exp);
        node_index = 3'(node);
        read_mem   = 1'b0;
        sample_req = 1'b1;
        exp_q.push_back(exp);
        tick();
        sample_req = 1'b0;
    endtask

    task automatic read_all(input logic [23:0] w [5]);
        for (int k = 0; k < 5; k++) rd(k, 0, w[k]);
    endtask

    task automatic clear();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    task automatic stream(input logic [23:0] w [5], input int nbits);
        for (int n = 0; n < nbits; n++) begin
            cfg_valid = 1'b1;
            cfg_bit   = w[n / 24][23 - (n % 24)];
            tick();
            cfg_valid = 1'b0;
        end
    endtask

    // Full 120-bit load; optionally reads slot 4 on the same edge as the final bit
    task automatic load5(input logic [23:0] w [5], input logic gap,
                         input logic rbw, input logic [23:0] rbw_exp);
        int n;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 23; i >= 0; i--) begin
                n++;
                cfg_valid = 1'b1;
                cfg_bit   = w[k][i];
                if (n == 120 && rbw) begin
                    node_index = 3'd4;
                    ch_index   = 1'b0;
                    read_mem   = 1'b1;
                    sample_req = 1'b1;
                    exp_q.push_back(rbw_exp);
                end
                tick();
                cfg_valid  = 1'b0;
                read_mem   = 1'b0;
                sample_req = 1'b0;
                if (n == 119) chk("ready_before_last_bit", 32'(mem_ready), 32'd0);
                if (n == 120) begin
                    chk("ready_on_last_bit", 32'(mem_ready), 32'd1);
                    chk("done_pulse", 32'(load_done), 32'd1);
                end
                if (gap) tick();
            end
        end
        tick();
        chk("done_drops", 32'(load_done), 32'd0);
        chk("ready_holds", 32'(mem_ready), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_node_data", 32'(node_data), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_overflow", 32'(cfg_overflow), 32'd0);
        reset_n = 1'b1;
        tick();

        // Continuous load of 1..5, then reads, hold and out-of-range addresses
        load5(w1, 1'b0, 1'b0, 24'h0);
        rd(3, 0, 24'h000004);
        hold(1, 24'h000004);
        read_all(w1);
        rd(5, 0, 24'h000000);
        rd(4, 0, 24'h000005);
        rd(7, 0, 24'h000000);
        rd(2, 0, 24'h000003);
        rd(0, 1, 24'h000000);

        // Extra bit when full, then clear and reload a uniform pattern
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("overflow_set", 32'(cfg_overflow), 32'd1);
        chk("ready_after_overflow", 32'(mem_ready), 32'd1);
        read_all(w1);
        clear();
        chk("clear_ready", 32'(mem_ready), 32'd0);
        chk("clear_overflow", 32'(cfg_overflow), 32'd0);
        load5(wa, 1'b0, 1'b0, 24'h0);
        read_all(wa);

        // Load with a one-cycle gap after every bit
        clear();
        load5(w1, 1'b1, 1'b0, 24'h0);
        read_all(w1);

        // cfg_clear together with cfg_valid on bit 50 drops that bit
        clear();
        stream(w5, 49);
        cfg_valid = 1'b1;
        cfg_bit   = ~w5[2][21];
        cfg_clear = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        chk("clear_mid_load_ready", 32'(mem_ready), 32'd0);
        load5(w5, 1'b0, 1'b0, 24'h0);
        read_all(w5);

        // Asynchronous reset in the middle of bit 70
        clear();
        stream(w6, 69);
        cfg_valid = 1'b1;
        cfg_bit   = w6[2][2];
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_node_data", 32'(node_data), 32'd0);
        chk("async_rst_ready", 32'(mem_ready), 32'd0);
        chk("async_rst_done", 32'(load_done), 32'd0);
        chk("async_rst_overflow", 32'(cfg_overflow), 32'd0);
        cfg_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        load5(w6, 1'b0, 1'b1, 24'hFFFFFF);
        read_all(w6);

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
